// File: rtl/sm3_compress_ctrl_if.sv
// Handshake and data bundle between the SM3 host logic and the compression engine.
// The host drives start/block/chaining value; the engine returns busy/done/result.
interface sm3_compress_ctrl_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] v_in;
    logic         busy;
    logic         done;
    logic [255:0] v_out;

    modport master (output start, block_in, v_in, input busy, done, v_out);
    modport slave  (input start, block_in, v_in, output busy, done, v_out);
endinterface

// File: rtl/sm3_compress_ctrl.sv
// Iterative SM3 compression: 64 rounds, one per clock, with on-the-fly message
// expansion from a 16-word sliding window. Result is V xor ABCDEFGH after round 63.
module sm3_compress_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    sm3_compress_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t       r_state;
    logic [5:0]   r_cnt;
    logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0] r_vreg;
    logic [255:0] r_v_out;
    logic         r_busy;
    logic         r_done;
    logic [31:0]  r_w [16];

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    // Round datapath: everything below depends only on the current round registers.
    logic        w_early;
    logic [31:0] w_t, w_a12, w_ss1, w_ss2, w_ff, w_gg, w_tt1, w_tt2, w_w_new;

    assign w_early = (r_cnt < 6'd16);
    assign w_t     = w_early ? 32'h79cc4519 : 32'h7a879d8a;
    assign w_a12   = rotl(r_a, 5'd12);
    assign w_ss1   = rotl(w_a12 + r_e + rotl(w_t, r_cnt[4:0]), 5'd7);
    assign w_ss2   = w_ss1 ^ w_a12;
    assign w_ff    = w_early ? (r_a ^ r_b ^ r_c) : ((r_a & r_b) | (r_a & r_c) | (r_b & r_c));
    assign w_gg    = w_early ? (r_e ^ r_f ^ r_g) : ((r_e & r_f) | (~r_e & r_g));
    assign w_tt1   = w_ff + r_d + w_ss2 + (r_w[0] ^ r_w[4]);
    assign w_tt2   = w_gg + r_h + w_ss1 + r_w[0];
    assign w_w_new = p1(r_w[0] ^ r_w[7] ^ rotl(r_w[13], 5'd15)) ^ rotl(r_w[3], 5'd7) ^ r_w[10];

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the round datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_v_out <= '0;
            r_vreg  <= '0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
            // NOTE: the window is a small register array, so clearing it on reset
            // is cheap and keeps state fully defined after an aborted run.
            for (int k = 0; k < 16; k++) r_w[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= bus.start;
                    if (bus.start) begin
                        r_vreg <= bus.v_in;
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= bus.v_in;
                        for (int k = 0; k < 16; k++) r_w[k] <= bus.block_in[511 - 32*k -: 32];
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a <= w_tt1;
                    r_b <= r_a;
                    r_c <= rotl(r_b, 5'd9);
                    r_d <= r_c;
                    r_e <= p0(w_tt2);
                    r_f <= r_e;
                    r_g <= rotl(r_f, 5'd19);
                    r_h <= r_g;
                    for (int k = 0; k < 15; k++) r_w[k] <= r_w[k+1];
                    r_w[15] <= w_w_new;
                    r_cnt   <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_v_out <= r_vreg ^ {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.v_out = r_v_out;
endmodule

// File: tb/tb_sm3_compress_ctrl.sv
// Self-checking bench for sm3_compress_ctrl: known SM3 vectors, random blocks
// against a full-schedule reference model, held start, mid-run reset, idle hold.
module tb_sm3_compress_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm3_compress_ctrl_if bus();
    sm3_compress_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] ABC_DIGEST = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] CHAIN_DIGEST = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ABCD_BLOCK1 = {16{32'h61626364}};
    localparam logic [511:0] ABCD_BLOCK2 = {32'h80000000, 448'h0, 32'h00000200};
    localparam int LATENCY = 65;
    localparam int WAIT_LIMIT = 200;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: whole message schedule W[0..67] built up front, textbook rounds.
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 9) ^ rotl(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    function automatic logic [255:0] sm3_ref(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w [0:67];
        logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2, ffv, ggv;
        for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
            ss2 = ss1 ^ rotl(a, 12);
            ffv = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            ggv = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ffv + d + ss2 + (w[j] ^ w[j+4]);
            tt2 = ggv + h + ss1 + w[j];
            d = c; c = rotl(b, 9); b = a; a = tt1;
            h = g; g = rotl(f, 19); f = e; e = p0(tt2);
        end
        return {a, b, c, d, e, f, g, h} ^ v;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Presents an operation for one edge, then scrambles the inputs.
    task automatic start_op(input logic [511:0] blk, input logic [255:0] v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.block_in = blk;
        bus.v_in = v;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.block_in = rand512();
        bus.v_in = rand256();
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat, output logic busy_ok);
        busy_ok = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (!bus.busy) busy_ok = 1'b0;
        end while (!bus.done && lat < WAIT_LIMIT);
    endtask

    task automatic run_and_check(input string tag, input logic [511:0] blk,
                                 input logic [255:0] v, input logic [255:0] exp);
        int lat;
        logic bok;
        start_op(blk, v);
        wait_done(lat, bok);
        check({tag, "_latency"}, 256'(lat), 256'(LATENCY));
        check({tag, "_busy_run"}, 256'(bok), 256'(1));
        check({tag, "_digest"}, bus.v_out, exp);
        @(posedge clk);
        #1;
        check({tag, "_release"}, {254'(0), bus.busy, bus.done}, 256'(0));
    endtask

    initial begin
        logic [255:0] mid, dig, v_r;
        logic [511:0] blk_r, blk;
        int done_cnt, lat_h, lat, bad;
        logic bok, seen_done;

        bus.start = 1'b0;
        bus.block_in = '0;
        bus.v_in = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_busy", 256'(bus.busy), 256'(0));
        check("reset_done", 256'(bus.done), 256'(0));
        check("reset_vout", bus.v_out, 256'(0));

        run_and_check("abc", ABC_BLOCK, IV, ABC_DIGEST);
        check("abc_model", bus.v_out, sm3_ref(IV, ABC_BLOCK));

        run_and_check("chain1", ABCD_BLOCK1, IV, sm3_ref(IV, ABCD_BLOCK1));
        mid = bus.v_out;
        run_and_check("chain2", ABCD_BLOCK2, mid, CHAIN_DIGEST);

        for (int i = 0; i < 4; i++) begin
            blk = rand512();
            v_r = rand256();
            run_and_check($sformatf("rand%0d", i), blk, v_r, sm3_ref(v_r, blk));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // start held high with inputs churning every cycle after acceptance
        @(negedge clk);
        bus.start = 1'b1;
        bus.block_in = ABC_BLOCK;
        bus.v_in = IV;
        @(posedge clk);
        done_cnt = 0;
        lat_h = 0;
        dig = '0;
        blk_r = '0;
        v_r = '0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            blk_r = rand512();
            v_r = rand256();
            bus.block_in = blk_r;
            bus.v_in = v_r;
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                lat_h = k;
                dig = bus.v_out;
            end
        end
        check("held_done_count", 256'(done_cnt), 256'(1));
        check("held_latency", 256'(lat_h), 256'(LATENCY));
        check("held_digest", dig, ABC_DIGEST);
        check("held_reaccept", 256'(bus.busy), 256'(1));
        @(negedge clk);
        bus.start = 1'b0;
        bus.block_in = rand512();
        wait_done(lat, bok);
        check("held2_latency", 256'(lat), 256'(LATENCY));
        check("held2_digest", bus.v_out, sm3_ref(v_r, blk_r));
        @(posedge clk);

        // reset during round 30
        start_op(ABC_BLOCK, IV);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", 256'(bus.busy), 256'(0));
        check("rst_async_vout", bus.v_out, 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
            if (bus.busy || bus.v_out !== '0) bad++;
        end
        check("rst_no_done", 256'(seen_done), 256'(0));
        check("rst_idle_state", 256'(bad), 256'(0));
        run_and_check("abc_after_rst", ABC_BLOCK, IV, ABC_DIGEST);

        // idle hold
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.v_out !== ABC_DIGEST || bus.busy || bus.done) bad++;
        end
        check("idle_hold", 256'(bad), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
